if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: credit-limited in-order requests to instruction memory, a small
// response FIFO toward IF/ID, and redirect handling. Define IF_FETCH_PERF_EN for perf counters.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        flush_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned SumW = CntW + 1;
  localparam logic [SumW-1:0] CreditLim = SumW'(MAX_OUTST);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTST - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     buf_pc_q    [MAX_OUTST];
  logic [31:0]     buf_instr_q [MAX_OUTST];

  logic            fifo_empty;
  logic            credit_ok;
  logic            handshake;
  logic            push;
  logic            pop;
  logic [CntW-1:0] live;
  logic [31:0]     resp_pc;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (!en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outstanding requests plus buffered entries never exceed the FIFO depth, so a
  // response always has a free slot waiting for it.
  assign fifo_empty = (cnt_q == '0);
  assign credit_ok  = ({1'b0, outst_q} + {1'b0, cnt_q}) < CreditLim;
  assign imem_req   = (state_q == StRun) & en & ~redirect_valid & credit_ok;
  assign imem_addr  = pc_q;
  assign handshake  = imem_req & imem_gnt;

  assign out_valid  = ~fifo_empty & en;
  assign out_pc     = fifo_empty ? '0 : buf_pc_q[rd_ptr_q];
  assign out_instr  = fifo_empty ? '0 : buf_instr_q[rd_ptr_q];
  assign pop        = out_valid & ~stall & ~redirect_valid;
  assign push       = imem_rvalid & (discard_q == '0) & ~redirect_valid;
  assign flush_o    = redirect_valid & rst_n;

  // Live (non-discarded) requests are consecutive words ending just below pc_q, so the
  // oldest one, which this response belongs to, sits live words back.
  assign live    = outst_q - discard_q;
  assign resp_pc = pc_q - (32'(live) << 2);

  always_comb begin
    outst_d = outst_q;
    if (handshake && !imem_rvalid) begin
      outst_d = outst_q + CntW'(1);
    end else if (!handshake && imem_rvalid) begin
      outst_d = outst_q - CntW'(1);
    end

    discard_d = discard_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      discard_d = imem_rvalid ? outst_q - CntW'(1) : outst_q;
    end else if (imem_rvalid && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (handshake) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (!push && pop) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the head is only visible while cnt_q is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= resp_pc;
      buf_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake && (fetch_cnt != 32'hFFFF_FFFF)) fetch_cnt <= fetch_cnt + 32'd1;
      if (out_valid && stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
